activation_scheduler: RTL and testbench
=======================================

# activation_scheduler

Sequences one inference window on a 2-lane spiking activation unit. On `start` it clears the activation elements, latches per-lane thresholds, and feeds `num_steps` membrane-potential samples through a valid/ready stream, one timestep per accepted sample. It then captures the per-lane accumulated spike counts into a result register held under a valid/ready handshake. It sits between the membrane-potential accumulation stage and the spike-count readout path.

## Interface
- `DATA_WIDTH`, 16, membrane potential / threshold width (signed)
- `TIMER_WIDTH`, 5, spike-count and step-count width
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a window; sampled only in IDLE
- `num_steps` in TIMER_WIDTH: timesteps in the window; latched on `start`
- `thr_in_0`, `thr_in_1` in DATA_WIDTH signed: lane thresholds; latched on `start`
- `mp_valid` in 1, `mp_ready` out 1: sample handshake
- `mp_0`, `mp_1` in DATA_WIDTH signed: per-lane membrane potential sample
- `act_rstn` out 1: active-low clear to the activation unit
- `act_step` out 1: one-cycle strobe; the activation unit consumes `act_mp_*` this cycle
- `act_mp_0`, `act_mp_1` out DATA_WIDTH: registered potentials; 0 whenever `act_step`=0
- `act_thr_0`, `act_thr_1` out DATA_WIDTH: latched thresholds
- `act_spikes_0`, `act_spikes_1` in TIMER_WIDTH: accumulated spikes from the activation unit
- `res_valid` out 1, `res_ready` in 1: result handshake
- `res_spikes_0`, `res_spikes_1` out TIMER_WIDTH: captured counts
- `res_steps` out TIMER_WIDTH: timesteps actually issued
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, CLEAR, STEP, SETTLE, RESULT.
- IDLE: `start`=1 latches `num_steps` and the thresholds, zeroes the step counter, and moves to CLEAR.
- CLEAR, exactly 1 cycle: `act_rstn`=0. Next state is STEP, or SETTLE if `num_steps`=0.
- STEP: `mp_ready`=1.
  - On `mp_valid&&mp_ready`, register `mp_*` into `act_mp_*`, pulse `act_step` next cycle, and increment the step counter.
  - On the handshake that makes counter == `num_steps`, go to SETTLE. `mp_ready` is 0 from the next cycle.
- SETTLE, 2 cycles, covering the in-flight step plus the element register update. On exit, capture `act_spikes_*` into `res_spikes_*` and the counter into `res_steps`, then go to RESULT.
- RESULT: `res_valid`=1 and outputs are held stable. `res_valid&&res_ready` returns to IDLE.
- `start` outside IDLE is ignored. `mp_valid` outside STEP is not accepted.
- Step counter is TIMER_WIDTH wide. `num_steps`=2^TIMER_WIDTH−1 is the maximum; the counter never wraps.

## Timing
- Reset values: `mp_ready`=0, `act_step`=0, `act_mp_*`=0, `act_thr_*`=0, `res_valid`=0, `res_spikes_*`=0, `res_steps`=0, `busy`=0, state IDLE.
- `act_rstn` = ~`rst` & ~(state==CLEAR). The activation unit is held cleared during `rst`.
- Handshake in cycle n gives `act_step`=1 with the sample in cycle n+1.
- Final handshake in cycle n gives `res_valid`=1 in cycle n+3.
- `start` in cycle s: CLEAR in s+1, and `mp_ready`=1 from s+2.
- Back-to-back samples run at 1 per cycle with no bubbles.
- `rst` asserted mid-window: IDLE next cycle, all outputs at reset values, any partial result discarded.
- Result stays valid indefinitely until `res_ready`. A new `start` is accepted in the cycle after the result handshake.

## Configuration
- `ACT_SCHED_EARLY_EXIT_EN` defined:
  - Adds input `exit_count` (TIMER_WIDTH).
  - In STEP, if `exit_count`≠0 and either `act_spikes_*` ≥ `exit_count`, `mp_ready` drops next cycle and the FSM goes to SETTLE.
  - `res_steps` reports the steps issued up to that point.
- Undefined: port absent; every window runs exactly `num_steps` steps.

## Test plan
- Reset, then `start` with `num_steps`=4, `thr`=100/200, `mp_valid` held high → `act_rstn` low exactly 1 cycle; 4 `act_step` pulses on consecutive cycles; `res_valid` 3 cycles after the 4th handshake; `res_steps`=4; `res_spikes` equal to the model counts.
- Same window with `mp_valid` toggling 1,0,1,0 → `act_step` only on the cycle after each handshake; `act_mp_*`=0 on idle cycles; `res_steps`=4.
- `num_steps`=0 → CLEAR, SETTLE, RESULT; no `act_step`; `res_steps`=0; `res_spikes`=0.
- `res_ready` held low 10 cycles, with `start` pulsed during RESULT → result stable, `start` ignored; IDLE after the handshake.
- `rst` pulsed during step 2 of 4 → all outputs at reset values next cycle; `act_rstn`=0 during `rst`; next `start` runs cleanly.
- `ACT_SCHED_EARLY_EXIT_EN` with `exit_count`=2, `num_steps`=20, lane 0 spiking every step → window stops early; `res_steps`<20; `res_spikes_0`≥2.

Source files
------------

// File: rtl/activation_scheduler_if.sv
// Bundle between the membrane-potential stage, the activation unit and the readout.
// master = scheduler side, slave = surrounding datapath.
interface activation_scheduler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int TIMER_WIDTH = 5
);
  logic                          mp_valid;
  logic                          mp_ready;
  logic signed [DATA_WIDTH-1:0]  mp_0;
  logic signed [DATA_WIDTH-1:0]  mp_1;
  logic                          act_rstn;
  logic                          act_step;
  logic signed [DATA_WIDTH-1:0]  act_mp_0;
  logic signed [DATA_WIDTH-1:0]  act_mp_1;
  logic signed [DATA_WIDTH-1:0]  act_thr_0;
  logic signed [DATA_WIDTH-1:0]  act_thr_1;
  logic [TIMER_WIDTH-1:0]        act_spikes_0;
  logic [TIMER_WIDTH-1:0]        act_spikes_1;
  logic                          res_valid;
  logic                          res_ready;
  logic [TIMER_WIDTH-1:0]        res_spikes_0;
  logic [TIMER_WIDTH-1:0]        res_spikes_1;
  logic [TIMER_WIDTH-1:0]        res_steps;

  modport master (
    input  mp_valid, mp_0, mp_1, act_spikes_0, act_spikes_1, res_ready,
    output mp_ready, act_rstn, act_step, act_mp_0, act_mp_1, act_thr_0, act_thr_1,
           res_valid, res_spikes_0, res_spikes_1, res_steps
  );

  modport slave (
    output mp_valid, mp_0, mp_1, act_spikes_0, act_spikes_1, res_ready,
    input  mp_ready, act_rstn, act_step, act_mp_0, act_mp_1, act_thr_0, act_thr_1,
           res_valid, res_spikes_0, res_spikes_1, res_steps
  );
endinterface

// File: rtl/activation_scheduler.sv
// Sequences one inference window (clear, N steps, settle, result) for a 2-lane spiking unit.
// Optional ACT_SCHED_EARLY_EXIT_EN stops the window once either lane reaches i_exit_count spikes.
module activation_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int TIMER_WIDTH = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [TIMER_WIDTH-1:0]        i_num_steps,
  input  logic signed [DATA_WIDTH-1:0]  i_thr_in_0,
  input  logic signed [DATA_WIDTH-1:0]  i_thr_in_1,
`ifdef ACT_SCHED_EARLY_EXIT_EN
  input  logic [TIMER_WIDTH-1:0]        i_exit_count,
`endif
  output logic                          o_busy,
  activation_scheduler_if.master        bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STEP, S_SETTLE, S_RESULT} state_t;

  state_t                       r_state;
  logic [TIMER_WIDTH-1:0]       r_num_steps;
  logic [TIMER_WIDTH-1:0]       r_cnt;
  logic                         r_settle;
  logic                         r_mp_ready;
  logic                         r_act_step;
  logic                         r_res_valid;
  logic                         r_busy;
  logic signed [DATA_WIDTH-1:0] r_act_mp_0;
  logic signed [DATA_WIDTH-1:0] r_act_mp_1;
  logic signed [DATA_WIDTH-1:0] r_thr_0;
  logic signed [DATA_WIDTH-1:0] r_thr_1;
  logic [TIMER_WIDTH-1:0]       r_res_spk_0;
  logic [TIMER_WIDTH-1:0]       r_res_spk_1;
  logic [TIMER_WIDTH-1:0]       r_res_steps;

  logic [TIMER_WIDTH-1:0]       w_cnt_inc;
  logic                         w_hs;
  logic                         w_last;
  logic                         w_exit;

  // r_mp_ready is only ever high in STEP, so it doubles as the state qualifier
  assign w_cnt_inc = r_cnt + TIMER_WIDTH'(1);
  assign w_hs      = bus.mp_valid & r_mp_ready;
  assign w_last    = w_hs && (w_cnt_inc == r_num_steps);

`ifdef ACT_SCHED_EARLY_EXIT_EN
  assign w_exit = (i_exit_count != '0) &&
                  ((bus.act_spikes_0 >= i_exit_count) || (bus.act_spikes_1 >= i_exit_count));
`else
  assign w_exit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_num_steps <= '0;
      r_cnt       <= '0;
      r_settle    <= 1'b0;
      r_mp_ready  <= 1'b0;
      r_act_step  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_act_mp_0  <= '0;
      r_act_mp_1  <= '0;
      r_thr_0     <= '0;
      r_thr_1     <= '0;
      r_res_spk_0 <= '0;
      r_res_spk_1 <= '0;
      r_res_steps <= '0;
    end else begin
      r_act_step <= 1'b0;
      r_act_mp_0 <= '0;
      r_act_mp_1 <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_steps <= i_num_steps;
            r_thr_0     <= i_thr_in_0;
            r_thr_1     <= i_thr_in_1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_num_steps == '0) begin
            r_state <= S_SETTLE;
          end else begin
            r_mp_ready <= 1'b1;
            r_state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (w_hs) begin
            r_act_step <= 1'b1;
            r_act_mp_0 <= bus.mp_0;
            r_act_mp_1 <= bus.mp_1;
            r_cnt      <= w_cnt_inc;
          end
          if (w_last || w_exit) begin
            r_mp_ready <= 1'b0;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // second cycle: the last step has landed in the element registers
          r_settle <= ~r_settle;
          if (r_settle) begin
            r_res_spk_0 <= bus.act_spikes_0;
            r_res_spk_1 <= bus.act_spikes_1;
            r_res_steps <= r_cnt;
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.act_rstn     = ~i_rst & (r_state != S_CLEAR);
  assign bus.mp_ready     = r_mp_ready;
  assign bus.act_step     = r_act_step;
  assign bus.act_mp_0     = r_act_mp_0;
  assign bus.act_mp_1     = r_act_mp_1;
  assign bus.act_thr_0    = r_thr_0;
  assign bus.act_thr_1    = r_thr_1;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_spikes_0 = r_res_spk_0;
  assign bus.res_spikes_1 = r_res_spk_1;
  assign bus.res_steps    = r_res_steps;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_activation_scheduler.sv
// Randomized window sequences against a sample-list spike model, with a simple
// threshold-compare activation unit closing the loop.
`timescale 1ns/1ps
module tb_activation_scheduler;
  localparam int DW = 16;
  localparam int TW = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [TW-1:0]        num_steps;
  logic signed [DW-1:0] thr0;
  logic signed [DW-1:0] thr1;
  logic                 busy;
`ifdef ACT_SCHED_EARLY_EXIT_EN
  logic [TW-1:0]        exit_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  activation_scheduler_if #(.DATA_WIDTH(DW), .TIMER_WIDTH(TW)) bus ();

  activation_scheduler #(.DATA_WIDTH(DW), .TIMER_WIDTH(TW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_num_steps (num_steps),
    .i_thr_in_0  (thr0),
    .i_thr_in_1  (thr1),
`ifdef ACT_SCHED_EARLY_EXIT_EN
    .i_exit_count(exit_count),
`endif
    .o_busy      (busy),
    .bus         (bus)
  );

  // Activation unit stand-in: a lane spikes on a step whose potential reaches its threshold.
  logic [TW-1:0] au_cnt0, au_cnt1;
  always @(posedge clk) begin
    if (!bus.act_rstn) begin
      au_cnt0 <= '0;
      au_cnt1 <= '0;
    end else if (bus.act_step) begin
      if (bus.act_mp_0 >= bus.act_thr_0) au_cnt0 <= au_cnt0 + TW'(1);
      if (bus.act_mp_1 >= bus.act_thr_1) au_cnt1 <= au_cnt1 + TW'(1);
    end
  end
  assign bus.act_spikes_0 = au_cnt0;
  assign bus.act_spikes_1 = au_cnt1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rdy"},   32'(bus.mp_ready), 0);
    chk({pfx, "_step"},  32'(bus.act_step), 0);
    chk({pfx, "_mp0"},   32'(bus.act_mp_0), 0);
    chk({pfx, "_mp1"},   32'(bus.act_mp_1), 0);
    chk({pfx, "_thr0"},  32'(bus.act_thr_0), 0);
    chk({pfx, "_thr1"},  32'(bus.act_thr_1), 0);
    chk({pfx, "_rvld"},  32'(bus.res_valid), 0);
    chk({pfx, "_rspk0"}, 32'(bus.res_spikes_0), 0);
    chk({pfx, "_rspk1"}, 32'(bus.res_spikes_1), 0);
    chk({pfx, "_rsteps"},32'(bus.res_steps), 0);
    chk({pfx, "_busy"},  32'(busy), 0);
    chk({pfx, "_rstn"},  32'(bus.act_rstn), 0);
  endtask

  // mode: 0 = valid every cycle, 1 = valid toggling 1,0,1,0, 2 = random valid
  task automatic run_window(input int n, input int t0, input int t1, input int mode, input int hold);
    int sent, k, e0, e1, m0, m1, l0, l1, exp_mp0, exp_mp1;
    logic pend, v;
    start = 1'b1; num_steps = TW'(n); thr0 = DW'(t0); thr1 = DW'(t1);
    tick();
    start = 1'b0; num_steps = '0;
    chk("clear_rstn", 32'(bus.act_rstn), 0);
    chk("clear_busy", 32'(busy), 1);
    chk("clear_rdy",  32'(bus.mp_ready), 0);
    tick();
    chk("thr0", 32'(bus.act_thr_0), t0);
    chk("thr1", 32'(bus.act_thr_1), t1);
    chk("rstn_after_clear", 32'(bus.act_rstn), 1);
    sent = 0; k = 0; e0 = 0; e1 = 0; l0 = 0; l1 = 0; pend = 1'b0;
    if (n == 0) begin
      chk("n0_rdy",  32'(bus.mp_ready), 0);
      chk("n0_step", 32'(bus.act_step), 0);
      tick();
      chk("n0_step2", 32'(bus.act_step), 0);
      chk("n0_rvld",  32'(bus.res_valid), 0);
      tick();
    end else begin
      while (sent < n && k < 400) begin
        exp_mp0 = pend ? l0 : 0;
        exp_mp1 = pend ? l1 : 0;
        chk("rdy",  32'(bus.mp_ready), 1);
        chk("step", 32'(bus.act_step), 32'(pend));
        chk("mp0",  32'(bus.act_mp_0), exp_mp0);
        chk("mp1",  32'(bus.act_mp_1), exp_mp1);
        case (mode)
          0:       v = 1'b1;
          1:       v = (k % 2) == 0;
          default: v = $urandom_range(0, 1) == 1;
        endcase
        m0 = t0 + int'($urandom_range(0, 100)) - 50;
        m1 = t1 + int'($urandom_range(0, 100)) - 50;
        bus.mp_valid = v; bus.mp_0 = DW'(m0); bus.mp_1 = DW'(m1);
        pend = v;
        if (v) begin
          sent++; l0 = m0; l1 = m1;
          if (m0 >= t0) e0++;
          if (m1 >= t1) e1++;
        end
        tick();
        k++;
      end
      bus.mp_valid = 1'b0;
      if (sent < n) chk("timeout_steps", 32'(sent), 32'(n));
      chk("last_step",  32'(bus.act_step), 1);
      chk("last_mp0",   32'(bus.act_mp_0), l0);
      chk("last_mp1",   32'(bus.act_mp_1), l1);
      chk("rdy_drop",   32'(bus.mp_ready), 0);
      chk("rvld_n1",    32'(bus.res_valid), 0);
      tick();
      chk("rvld_n2",    32'(bus.res_valid), 0);
      chk("settle_step",32'(bus.act_step), 0);
      chk("settle_mp0", 32'(bus.act_mp_0), 0);
      tick();
    end
    chk("res_valid", 32'(bus.res_valid), 1);
    chk("res_steps", 32'(bus.res_steps), n);
    chk("res_spk0",  32'(bus.res_spikes_0), e0);
    chk("res_spk1",  32'(bus.res_spikes_1), e1);
    for (int h = 0; h < hold; h++) begin
      start = (h == 3); num_steps = TW'(7);
      tick();
      chk("hold_valid", 32'(bus.res_valid), 1);
      chk("hold_steps", 32'(bus.res_steps), n);
      chk("hold_spk0",  32'(bus.res_spikes_0), e0);
      chk("hold_spk1",  32'(bus.res_spikes_1), e1);
      chk("hold_busy",  32'(busy), 1);
    end
    start = 1'b0; num_steps = '0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("done_valid", 32'(bus.res_valid), 0);
    chk("done_busy",  32'(busy), 0);
    chk("done_rstn",  32'(bus.act_rstn), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_steps = '0; thr0 = '0; thr1 = '0;
    bus.mp_valid = 1'b0; bus.mp_0 = '0; bus.mp_1 = '0; bus.res_ready = 1'b0;
`ifdef ACT_SCHED_EARLY_EXIT_EN
    exit_count = '0;
`endif
    tick(); tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_rstn", 32'(bus.act_rstn), 1);
    chk("idle_busy", 32'(busy), 0);

    run_window(4, 100, 200, 0, 0);
    run_window(4, 100, 200, 1, 0);
    run_window(0, 100, 200, 0, 0);
    run_window(3, 50, -20, 0, 10);

    // reset in the middle of a 4-step window
    start = 1'b1; num_steps = TW'(4); thr0 = DW'(100); thr1 = DW'(200);
    tick();
    start = 1'b0;
    tick();
    bus.mp_valid = 1'b1; bus.mp_0 = DW'(150); bus.mp_1 = DW'(250);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_rstn_comb", 32'(bus.act_rstn), 0);
    bus.mp_valid = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    run_window(4, 100, 200, 0, 0);

    run_window(31, 10, -10, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_window(int'($urandom_range(1, 12)), int'($urandom_range(0, 400)) - 200,
                 int'($urandom_range(0, 400)) - 200, 2, int'($urandom_range(0, 3)));
    end

`ifdef ACT_SCHED_EARLY_EXIT_EN
    begin
      int hs, k;
      exit_count = TW'(2);
      start = 1'b1; num_steps = TW'(20); thr0 = DW'(-100); thr1 = DW'(1000);
      tick();
      start = 1'b0;
      tick();
      bus.mp_valid = 1'b1; bus.mp_0 = '0; bus.mp_1 = '0;
      hs = 0; k = 0;
      while (!bus.res_valid && k < 100) begin
        if (bus.mp_ready) hs++;
        tick();
        k++;
      end
      bus.mp_valid = 1'b0;
      chk("early_res_valid", 32'(bus.res_valid), 1);
      chk("early_lt_max",    32'(bus.res_steps < TW'(20)), 1);
      chk("early_steps",     32'(bus.res_steps), hs);
      chk("early_spk0",      32'(bus.res_spikes_0), hs);
      chk("early_spk0_ge",   32'(bus.res_spikes_0 >= TW'(2)), 1);
      chk("early_spk1",      32'(bus.res_spikes_1), 0);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      exit_count = '0;
      chk("early_done", 32'(busy), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
